// File: rtl/prn_pkg.sv
// Shared definitions for the PRN code correlator: FSM state type, default code
// length (common with the generator) and a counter-width helper.
package prn_pkg;

  localparam int PRN_CODE_LEN = 10230;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DWELL,
    ST_EVAL,
    ST_SLIP,
    ST_TRACK
  } state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prn_code_correlator_if.sv
// Chip-stream bundle between the front-end slicer / replica generator and the
// correlator: received chips plus the replica handshake.
interface prn_code_correlator_if;
  logic rx_chip;
  logic rx_valid;
  logic rep_chip;
  logic rep_valid;
  logic rep_ready;

  modport master (
    output rx_chip, rx_valid, rep_chip, rep_valid,
    input  rep_ready
  );

  modport slave (
    input  rx_chip, rx_valid, rep_chip, rep_valid,
    output rep_ready
  );
endinterface

// File: rtl/prn_corr_acc.sv
// Per-dwell correlation accumulator: signed +/-1 sum of chip agreements, chip
// counter, and a flag marking the final chip position of the dwell.
module prn_corr_acc #(
  parameter int CODE_LEN = 10230,
  parameter int ACC_W    = 15,
  parameter int PH_W     = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    match,
  output logic signed [ACC_W-1:0] acc,
  output logic                    last
);

  localparam logic signed [ACC_W-1:0] ONE = 1;

  logic [PH_W-1:0] chip_cnt;

  assign last = (chip_cnt == PH_W'(CODE_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      chip_cnt <= '0;
    end else if (clr) begin
      acc      <= '0;
      chip_cnt <= '0;
    end else if (en) begin
      acc      <= match ? acc + ONE : acc - ONE;
      chip_cnt <= chip_cnt + PH_W'(1);
    end
  end

endmodule

// File: rtl/prn_code_correlator.sv
// Serial-search PRN code correlator: dwells one code period per replica phase,
// slips the replica one chip on a miss, and tracks once |corr| crosses THRESH.
module prn_code_correlator
  import prn_pkg::*;
#(
  parameter int CODE_LEN = PRN_CODE_LEN,
  parameter int ACC_W    = 15,
  parameter int PH_W     = 14,
  parameter int THRESH   = 7000,
  parameter int MAX_MISS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  prn_code_correlator_if.slave    chip_if,
  output logic signed [ACC_W-1:0] corr_val,
  output logic                    corr_strobe,
  output logic                    locked,
  output logic                    polarity,
  output logic [PH_W-1:0]         code_phase,
  output logic                    busy,
  output logic                    acq_fail,
  output logic                    overrun
);

  localparam int TRY_W  = cnt_width(CODE_LEN + 1);
  localparam int MISS_W = cnt_width(MAX_MISS + 1);
  localparam logic signed [ACC_W-1:0] ONE = 1;

  state_t                    state;
  logic [TRY_W-1:0]          tried_cnt;
  logic [MISS_W-1:0]         miss_cnt;
  logic [TRY_W-1:0]          tried_inc;
  logic [MISS_W-1:0]         miss_inc;
  logic                      in_corr;
  logic                      accept;
  logic                      match;
  logic                      acc_clr;
  logic                      last;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_final;
  logic [ACC_W-1:0]          mag;

  assign in_corr = (state == ST_DWELL) || (state == ST_TRACK);
  assign chip_if.rep_ready = (state == ST_SLIP) || (in_corr && chip_if.rx_valid);
  assign accept  = in_corr && chip_if.rx_valid && chip_if.rep_valid && !start;
  assign match   = (chip_if.rx_chip == chip_if.rep_chip);
  assign acc_clr = start || (state == ST_EVAL);

  // corr_val must be ready the cycle after the last accept, so it captures the
  // accumulator value including that final chip.
  assign acc_final = match ? acc + ONE : acc - ONE;
  assign mag       = corr_val[ACC_W-1] ? ACC_W'(-corr_val) : ACC_W'(corr_val);
  assign tried_inc = tried_cnt + TRY_W'(1);
  assign miss_inc  = miss_cnt + MISS_W'(1);

  prn_corr_acc #(
    .CODE_LEN (CODE_LEN),
    .ACC_W    (ACC_W),
    .PH_W     (PH_W)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (accept),
    .match (match),
    .acc   (acc),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      corr_val    <= '0;
      corr_strobe <= 1'b0;
      locked      <= 1'b0;
      polarity    <= 1'b0;
      code_phase  <= '0;
      busy        <= 1'b0;
      acq_fail    <= 1'b0;
      overrun     <= 1'b0;
      tried_cnt   <= '0;
      miss_cnt    <= '0;
    end else if (start) begin
      state       <= ST_DWELL;
      busy        <= 1'b1;
      corr_strobe <= 1'b0;
      locked      <= 1'b0;
      code_phase  <= '0;
      acq_fail    <= 1'b0;
      overrun     <= 1'b0;
      tried_cnt   <= '0;
      miss_cnt    <= '0;
    end else begin
      corr_strobe <= 1'b0;
      case (state)
        ST_DWELL, ST_TRACK: begin
          if (chip_if.rx_valid && !chip_if.rep_valid)
            overrun <= 1'b1;
          if (accept && last) begin
            corr_val    <= acc_final;
            corr_strobe <= 1'b1;
            state       <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (mag >= ACC_W'(THRESH)) begin
            state    <= ST_TRACK;
            locked   <= 1'b1;
            miss_cnt <= '0;
            polarity <= corr_val[ACC_W-1];
          end else if (!locked) begin
            tried_cnt <= tried_inc;
            if (tried_inc == TRY_W'(CODE_LEN)) begin
              acq_fail <= 1'b1;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              state <= ST_SLIP;
            end
          end else if (miss_inc == MISS_W'(MAX_MISS)) begin
            // Lock lost: fall back to a fresh serial search from the next phase.
            locked    <= 1'b0;
            miss_cnt  <= '0;
            tried_cnt <= '0;
            state     <= ST_SLIP;
          end else begin
            miss_cnt <= miss_inc;
            state    <= ST_TRACK;
          end
        end
        ST_SLIP: begin
          if (chip_if.rep_valid) begin
            code_phase <= (code_phase == PH_W'(CODE_LEN - 1)) ? '0 : code_phase + PH_W'(1);
            state      <= ST_DWELL;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prn_code_correlator.sv
// Randomized scoreboard bench: a dwell-level reference model predicts every
// correlation result; a monitor compares at each corr_strobe and one cycle later.
module tb_prn_code_correlator;
  localparam int L = 127;
  localparam int MEM = 20000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] corr_val;
  logic       corr_strobe, locked, polarity, busy, acq_fail, overrun;
  logic [6:0] code_phase;

  prn_code_correlator_if chip_if ();

  prn_code_correlator #(
    .CODE_LEN (L), .ACC_W (8), .PH_W (7), .THRESH (100), .MAX_MISS (2)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .chip_if (chip_if),
    .corr_val (corr_val), .corr_strobe (corr_strobe), .locked (locked),
    .polarity (polarity), .code_phase (code_phase), .busy (busy),
    .acq_fail (acq_fail), .overrun (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int corr; int phase; bit lk_pre; bit lk; bit pol; bit fail; bit ov;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  bit   pend = 1'b0;
  bit   mseq [L];
  bit   tx_mem [MEM];
  bit   pol_m = 1'b0;
  int   total = 0, bad = 0;
  int   cyc = 0, start_cyc = 0, strobe_cyc = 0, n_strobe = 0;
  int   a = 0, r = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Dwell-level model: correlation over a full period at the replica offset
  // implied by the number of slips so far, then the lock/miss/search rules.
  task automatic predict(input int ndw, input bit ov);
    int k = 0, a0 = 0, tried = 0, miss = 0;
    bit lk = 1'b0;
    for (int d = 0; d < ndw; d++) begin
      exp_t e;
      int c = 0;
      for (int i = 0; i < L; i++)
        c += (tx_mem[a0 + i] == mseq[(a0 + i + k) % L]) ? 1 : -1;
      e.corr = c; e.phase = k % L; e.lk_pre = lk; e.ov = ov; e.fail = 1'b0;
      if (c >= 100 || c <= -100) begin
        lk = 1'b1; miss = 0; pol_m = (c < 0);
      end else if (!lk) begin
        tried++;
        if (tried == L) e.fail = 1'b1;
        else k++;
      end else begin
        miss++;
        if (miss == 2) begin lk = 1'b0; miss = 0; tried = 0; k++; end
      end
      e.lk = lk; e.pol = pol_m;
      sbq.push_back(e);
      a0 += L;
      if (e.fail) break;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        chk("locked_n2", int'(locked), int'(cur.lk));
        chk("polarity_n2", int'(polarity), int'(cur.pol));
        chk("acq_fail_n2", int'(acq_fail), int'(cur.fail));
        chk("busy_n2", int'(busy), int'(!cur.fail));
        chk("overrun_n2", int'(overrun), int'(cur.ov));
      end
      if (rst_n && corr_strobe) begin
        strobe_cyc = cyc;
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_strobe: got corr_val=%0d, expected no strobe", $signed(corr_val));
        end else begin
          cur = sbq.pop_front();
          n_strobe++;
          $display("dwell %0d: corr_val=%0d (model %0d) code_phase=%0d (model %0d)",
                   n_strobe, $signed(corr_val), cur.corr, code_phase, cur.phase);
          chk("corr_val", int'($signed(corr_val)), cur.corr);
          chk("code_phase", int'(code_phase), cur.phase);
          chk("locked_n1", int'(locked), int'(cur.lk_pre));
          pend = 1'b1;
        end
      end
    end
  end

  task automatic idle_cycle();
    @(posedge clk); #1;
    start = 1'b0; chip_if.rx_valid = 1'b0; chip_if.rep_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1; chip_if.rx_valid = 1'b0; chip_if.rep_valid = 1'b0;
    a = 0; r = 0; start_cyc = cyc;
  endtask

  // rx_valid=0 probe exposes SLIP (the only state with rep_ready=1 then), so
  // the bench knows whether a handshake consumes an rx chip or only a replica chip.
  task automatic drive_cycle(input bit gap, input bit dense);
    bit rv, pv, slip;
    @(posedge clk); #1;
    start = 1'b0; chip_if.rx_valid = 1'b0; chip_if.rep_valid = 1'b0;
    #1;
    slip = chip_if.rep_ready;
    rv = gap || dense || ($urandom_range(0, 7) != 0);
    pv = gap ? 1'b0 : (rv ? 1'b1 : ($urandom_range(0, 1) == 1));
    chip_if.rx_valid = rv; chip_if.rep_valid = pv;
    chip_if.rx_chip = (a < MEM) ? tx_mem[a] : 1'b0;
    chip_if.rep_chip = mseq[r % L];
    #1;
    if (chip_if.rep_ready && pv) begin
      r++;
      if (!slip) a++;
    end
  endtask

  task automatic run_scn(input string name, input int budget, input bit dense,
                         input int gap_lo, input int gap_hi);
    int j = 0;
    while ((sbq.size() > 0 || pend) && j < budget) begin
      drive_cycle(j >= gap_lo && j < gap_hi, dense);
      j++;
    end
    if (j >= budget) begin
      total++; bad++;
      $display("FAIL %s_timeout: got %0d dwells outstanding after %0d cycles, expected 0",
               name, sbq.size(), budget);
      sbq.delete(); pend = 1'b0;
    end
    idle_cycle(); idle_cycle();
  endtask

  initial begin
    bit s [L + 7];
    s[0] = 1'b1;
    for (int i = 1; i < 7; i++) s[i] = 1'b0;
    for (int n = 0; n < L; n++) s[n + 7] = s[n + 1] ^ s[n];
    for (int i = 0; i < L; i++) mseq[i] = s[i];

    chip_if.rx_chip = 1'b0; chip_if.rep_chip = 1'b0;
    chip_if.rx_valid = 1'b1; chip_if.rep_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_corr_val", int'(corr_val), 0);
    chk("rst_code_phase", int'(code_phase), 0);
    chk("rst_flags", int'({corr_strobe, locked, polarity, acq_fail, overrun}), 0);
    chk("rst_rep_ready", int'(chip_if.rep_ready), 0);
    rst_n = 1'b1;
    idle_cycle(); idle_cycle();

    // Zero offset: rx equals the replica.
    for (int i = 0; i < 2 * L; i++) tx_mem[i] = mseq[i % L];
    pulse_start(); predict(2, 1'b0);
    run_scn("zero_offset", 2000, 1'b0, -1, -1);

    // Offset 5, then uncorrelated data: lock, drop lock, full failed search.
    for (int i = 0; i < MEM; i++)
      tx_mem[i] = (i < 6 * L) ? mseq[(i + 5) % L] : 1'($urandom_range(0, 1));
    pulse_start(); predict(200, 1'b0);
    run_scn("offset5_search", 90000, 1'b0, -1, -1);
    chk("final_busy", int'(busy), 0);

    // Inverted rx.
    for (int i = 0; i < 2 * L; i++) tx_mem[i] = !mseq[i % L];
    pulse_start(); predict(2, 1'b0);
    run_scn("inverted", 2000, 1'b0, -1, -1);

    // Replica gap of 3 rx chips mid-dwell, then asynchronous reset mid-dwell.
    for (int i = 0; i < 2 * L; i++) tx_mem[i] = mseq[i % L];
    pulse_start(); predict(1, 1'b1);
    for (int j = 0; j < 200 && (sbq.size() > 0 || pend); j++)
      drive_cycle(j >= 40 && j < 43, 1'b1);
    chk("gap_dwell_len", strobe_cyc - start_cyc, L + 4);
    chk("gap_queue_empty", sbq.size(), 0);
    for (int j = 0; j < 30; j++) drive_cycle(1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_corr_val", int'(corr_val), 0);
    chk("arst_code_phase", int'(code_phase), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_flags", int'({corr_strobe, locked, polarity, acq_fail, overrun}), 0);
    chk("arst_rep_ready", int'(chip_if.rep_ready), 0);
    idle_cycle();
    rst_n = 1'b1;
    idle_cycle(); idle_cycle();
    chk("post_rst_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prn_code_correlator.md
# prn_code_correlator

Receive-side counterpart of the PRN code generator: correlates an incoming hard-decision chip stream against the local replica chip stream over one full code period (dwell). It slides the replica phase one chip at a time until the correlation magnitude crosses a threshold, then tracks. The block sits between the front-end chip slicer and the navigation-data stage. It reports the code phase, lock status, per-dwell correlation value, and data-bit polarity.

## Interface
- CODE_LEN, 10230: chips per code period and per dwell.
- ACC_W, 15: signed accumulator width; must hold ±CODE_LEN.
- PH_W, 14: code phase / counter width, ≥ clog2(CODE_LEN).
- THRESH, 7000: lock threshold on |corr|, unsigned, < CODE_LEN.
- MAX_MISS, 2: number of consecutive sub-threshold dwells in TRACK that drop lock.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; (re)starts acquisition from any state.
- rx_chip  in  1  received chip (0/1).
- rx_valid  in  1  rx_chip strobe; the front-end cannot stall.
- rep_chip  in  1  local replica chip from the generator.
- rep_valid  in  1  rep_chip is available.
- rep_ready  out  1  the replica chip is consumed when rep_ready & rep_valid.
- corr_val  out  ACC_W  signed correlation of the last completed dwell.
- corr_strobe  out  1  one-cycle pulse when corr_val updates.
- locked  out  1  lock indicator.
- polarity  out  1  sign of the last locking corr_val; 1 means negative (inverted data).
- code_phase  out  PH_W  replica chips slipped, modulo CODE_LEN.
- busy  out  1  high whenever the state is not IDLE.
- acq_fail  out  1  sticky; set when all CODE_LEN phases were tried without lock.
- overrun  out  1  sticky; set when rx_valid=1 and rep_valid=0 in DWELL or TRACK.

## Operation
- States: IDLE, DWELL, EVAL, SLIP, TRACK.
- Reset values: state=IDLE. All outputs are 0, including corr_val, code_phase, acq_fail and overrun. Accumulator, chip_cnt, miss_cnt and tried_cnt are 0.
- IDLE -> DWELL on start. start clears the accumulator, chip_cnt, code_phase, tried_cnt, miss_cnt, locked, acq_fail and overrun.
- start in any other state behaves identically; it overrides all other transitions in that cycle.
- Accept rule, in DWELL or TRACK: rep_ready = rx_valid. A pair is accepted when rx_valid & rep_valid.
  - On accept, acc += (rx_chip==rep_chip) ? +1 : −1, and chip_cnt increments.
- rx_valid without rep_valid: the rx chip is dropped, nothing accumulates, and overrun sets.
- When an accept occurs with chip_cnt==CODE_LEN−1, the next state is EVAL.
- EVAL (one cycle):
  - corr_strobe=1; corr_val is the final acc value.
  - acc and chip_cnt clear.
- EVAL decision, with |corr| ≥ THRESH:
  - Next state TRACK; locked=1; miss_cnt=0; polarity=corr sign.
- EVAL decision, with |corr| < THRESH while in acquisition:
  - tried_cnt increments.
  - If tried_cnt reaches CODE_LEN: acq_fail=1 and next state IDLE.
  - Otherwise next state SLIP.
- EVAL decision, with |corr| < THRESH while tracking:
  - miss_cnt increments.
  - If miss_cnt==MAX_MISS: locked=0, miss_cnt=0 and next state SLIP (acquisition resumes; tried_cnt resets).
  - Otherwise next state TRACK.
- SLIP: rep_ready=1 regardless of rx_valid; rx chips are ignored and overrun is not set.
  - On rep_valid, one replica chip is discarded.
  - code_phase wraps CODE_LEN−1 -> 0; otherwise it increments.
  - Next state DWELL.
- TRACK accumulates exactly like DWELL, and each dwell ends in EVAL.
- Arithmetic: acc is two's-complement ACC_W bits and cannot overflow because CODE_LEN ≤ 2^(ACC_W−1)−1. |corr| is computed in ACC_W bits.

## Timing
- Last accepted chip at cycle N -> corr_strobe and corr_val valid at N+1.
- locked, polarity and the next state are visible at N+2.
- The first accept in the new dwell can occur at N+2.
- A SLIP lasts ≥1 cycle and holds until rep_valid.
- rep_ready is combinational from state and rx_valid; all other outputs are registered.
- Reset mid-operation takes effect asynchronously and returns every output to its reset value. No accept is possible while rst_n=0.

## Structure
- Package prn_pkg holds:
  - the state enum typedef;
  - CODE_LEN default 10230, shared with the generator;
  - a clog2-based width helper.
- Sub-module prn_corr_acc contains the accumulator, chip counter and end-of-dwell detect.
  - Ports: clr, en, match, acc, last.
  - The FSM, phase/miss/tried counters and flags stay in the top level.

## Test plan
Overrides for all tests: CODE_LEN=127 (m-sequence), THRESH=100, MAX_MISS=2, ACC_W=8, PH_W=7.
- Zero offset: rx = replica -> first corr_val=127, locked=1 at N+2, code_phase=0, polarity=0.
- Offset 5: rx leads the replica by 5 chips -> 5 dwells with corr_val=−1 (m-sequence off-peak), then corr_val=127, code_phase=5, locked=1.
- Inverted rx -> corr_val=−127, locked=1, polarity=1.
- After lock, rx switched to an uncorrelated sequence -> two strobes below 100 keep locked=1 through the first; locked=0 after the second; state SLIP; code_phase increments.
- Uncorrelated rx for 127 dwells -> acq_fail=1, busy=0; code_phase wraps 126 -> 0 once.
- rep_valid held low for 3 rx_valid cycles mid-dwell -> overrun=1, and the dwell end is delayed by 3 accepts. Then assert rst_n=0 mid-dwell -> all outputs return to 0 immediately.
